sample_mixer_stage: RTL and testbench

//  Per-sample two-source mixer feeding the I2S playback serializer on the mclk domain.
//  - On each serializer request it reads one BRAM-clip sample and takes one player-module sample.
//  - Each source is attenuated by its own arithmetic right shift; the two are summed, saturated
//    to SAMPLE_BITS and master-attenuated.
//  - Result is presented as one out_valid-qualified sample; clip and drop statistics are kept.

---
 rtl/sample_mixer_stage.sv | 98 +++++++++
 tb/tb_sample_mixer_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sample_mixer_stage.sv
// sample_mixer_stage: clip + player sample mixer with per-source and master shift attenuation
module sample_mixer_stage #(
  parameter int SAMPLE_BITS = 16,
  parameter int ADDR_BITS   = 8,
  parameter int VOLUME_BITS = 8,
  parameter int P_TIMEOUT   = 64
) (
  input  logic                   mclk,
  input  logic                   rstn,
  input  logic                   req,
  input  logic [ADDR_BITS-1:0]   req_index,
  output logic                   buf_rd,
  output logic [ADDR_BITS-1:0]   buf_addr,
  input  logic [SAMPLE_BITS-1:0] buf_data,
  input  logic [SAMPLE_BITS-1:0] p_sample,
  input  logic                   p_valid,
  output logic                   p_ready,
  input  logic [VOLUME_BITS-1:0] bram_vol,
  input  logic [VOLUME_BITS-1:0] player_vol,
  input  logic [VOLUME_BITS-1:0] master_vol,
  output logic [SAMPLE_BITS-1:0] out_sample,
  output logic                   out_valid,
  output logic                   busy,
  output logic [15:0]            clip_cnt,
  output logic [15:0]            drop_cnt
);
  localparam int TW = $clog2(P_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RD, PLAY, MIX, OUT} state_t;
  state_t state, state_nx;
  logic [ADDR_BITS-1:0] idx;
  logic [VOLUME_BITS-1:0] bv, pv, mv;
  logic signed [SAMPLE_BITS-1:0] b, p, sat;
  logic signed [SAMPLE_BITS:0] be, pe, sum;
  logic [TW-1:0] tmr;
  logic timeout, clip;
  logic [1:0] drop_n;
  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, c} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
  always_comb begin
    timeout = state == PLAY && !p_valid && tmr == TW'(P_TIMEOUT);
    busy = state != IDLE;
    buf_rd = state == RD;
    buf_addr = buf_rd ? idx : '0;
    p_ready = state == PLAY;
    out_valid = state == OUT;
    drop_n = {1'b0, req & busy} + {1'b0, timeout};
    be = $signed({b[SAMPLE_BITS-1], b}) >>> bv;
    pe = $signed({p[SAMPLE_BITS-1], p}) >>> pv;
    sum = be + pe;
    clip = sum[SAMPLE_BITS] != sum[SAMPLE_BITS-1];
    sat = clip ? {sum[SAMPLE_BITS], {(SAMPLE_BITS-1){~sum[SAMPLE_BITS]}}} : sum[SAMPLE_BITS-1:0];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req ? RD : IDLE;
      RD:      state_nx = PLAY;
      PLAY:    state_nx = (p_valid || timeout) ? MIX : PLAY;
      MIX:     state_nx = OUT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge mclk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge mclk or negedge rstn)
    if (!rstn) begin
      idx <= '0;
      bv <= '0;
      pv <= '0;
      mv <= '0;
      b <= '0;
      p <= '0;
      tmr <= '0;
      out_sample <= '0;
      clip_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == IDLE && req) begin
        idx <= req_index;
        bv <= bram_vol;
        pv <= player_vol;
        mv <= master_vol;
      end
      tmr <= state == PLAY ? tmr + TW'(1) : '0;
      if (state == PLAY && tmr == '0) b <= buf_data;
      // a timeout leaves p at 0 because p_valid was low on the final PLAY cycle
      if (state == PLAY) p <= p_valid ? p_sample : '0;
      if (state == MIX) begin
        out_sample <= sat >>> mv;
        clip_cnt <= sat_inc(clip_cnt, {1'b0, clip});
      end
      drop_cnt <= sat_inc(drop_cnt, drop_n);
    end
endmodule

// File: tb/tb_sample_mixer_stage.sv
// tb_sample_mixer_stage: directed vectors against an arithmetic model of the mixer
module tb_sample_mixer_stage;
  localparam int SB = 16, AB = 8, VB = 8, PT = 64;
  logic mclk = 0, rstn = 0, req = 0, p_valid = 0;
  logic [AB-1:0] req_index = 0;
  logic buf_rd, p_ready, out_valid, busy;
  logic [AB-1:0] buf_addr;
  logic [SB-1:0] buf_data = 0, p_sample = 0, out_sample;
  logic [VB-1:0] bram_vol = 0, player_vol = 0, master_vol = 0;
  logic [15:0] clip_cnt, drop_cnt;
  int total = 0, bad = 0, cyc = 0, hold = 0, mclip = 0, mdrop = 0;
  typedef struct {int c; int v;} exp_t;
  exp_t q[$];
  logic [SB-1:0] mem [256];

  sample_mixer_stage #(.SAMPLE_BITS(SB), .ADDR_BITS(AB), .VOLUME_BITS(VB), .P_TIMEOUT(PT)) dut (
    .mclk(mclk), .rstn(rstn), .req(req), .req_index(req_index),
    .buf_rd(buf_rd), .buf_addr(buf_addr), .buf_data(buf_data),
    .p_sample(p_sample), .p_valid(p_valid), .p_ready(p_ready),
    .bram_vol(bram_vol), .player_vol(player_vol), .master_vol(master_vol),
    .out_sample(out_sample), .out_valid(out_valid), .busy(busy),
    .clip_cnt(clip_cnt), .drop_cnt(drop_cnt));

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;
  always @(posedge mclk) if (buf_rd) buf_data <= mem[buf_addr];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // floor(x / 2^s), saturating to 0/-1 once the whole sample is shifted out
  function automatic int shr(input int x, input int s);
    int d;
    if (s >= SB) return x < 0 ? -1 : 0;
    d = 1 << s;
    return x >= 0 ? x / d : -((-x + d - 1) / d);
  endfunction

  function automatic int mix(input int b, p, bv, pv, mv, output bit c);
    int s;
    s = shr(b, bv) + shr(p, pv);
    c = s > 32767 || s < -32768;
    s = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
    return shr(s, mv);
  endfunction

  always @(negedge mclk) begin
    if (!rstn) hold = 0;
    if (q.size() > 0 && q[0].c == cyc) begin
      chk("out_valid_hi", int'(out_valid), 1);
      hold = q[0].v;
      void'(q.pop_front());
    end else chk("out_valid_lo", int'(out_valid), 0);
    chk("out_sample", int'($signed(out_sample)), hold);
  end

  task automatic issue(input int idx, output int n);
    @(posedge mclk); #1;
    req_index = AB'(idx);
    req = 1;
    n = cyc;
    @(posedge mclk); #1;
    req = 0;
  endtask

  task automatic txn(input int idx, b, p, bv, pv, mv);
    int n, v;
    bit c;
    mem[idx] = 16'(b);
    p_sample = 16'(p);
    p_valid = 1;
    bram_vol = VB'(bv);
    player_vol = VB'(pv);
    master_vol = VB'(mv);
    v = mix(b, p, bv, pv, mv, c);
    issue(idx, n);
    q.push_back('{n + 4, v});
    if (c) mclip++;
    chk("buf_rd", int'(buf_rd), 1);
    chk("buf_addr", int'(buf_addr), idx);
    bram_vol = ~bram_vol;
    player_vol = ~player_vol;
    master_vol = ~master_vol;
    repeat (4) @(posedge mclk);
    #1;
    chk("clip_cnt", int'(clip_cnt), mclip);
    chk("drop_cnt", int'(drop_cnt), mdrop);
  endtask

  int tv [6][6] = '{
    '{-5, 0, 16, 0, 0, 1},
    '{32767, 32767, 1, 1, 0, 2},
    '{-32768, -32768, 1, 1, 0, 254},
    '{-32768, -1, 0, 0, 0, 0},
    '{12345, -2345, 2, 3, 2, 128},
    '{100, -100, 255, 255, 20, 77}};

  initial begin
    int n;
    bit c;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_buf_rd", int'(buf_rd), 0);
    chk("rst_buf_addr", int'(buf_addr), 0);
    chk("rst_p_ready", int'(p_ready), 0);
    chk("rst_clip", int'(clip_cnt), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    @(posedge mclk); #1;
    rstn = 1;
    chk("pin_latency", mix(1000, 200, 0, 0, 0, c), 1200);
    chk("pin_possat", mix(30000, 10000, 0, 0, 0, c), 32767);
    chk("pin_negsat", mix(-30000, -10000, 0, 0, 1, c), -16384);
    chk("pin_atten", mix(-4, 8, 1, 20, 0, c), -2);
    txn(5, 1000, 200, 0, 0, 0);
    txn(255, 30000, 10000, 0, 0, 0);
    chk("clip_t2", int'(clip_cnt), 1);
    txn(0, -30000, -10000, 0, 0, 1);
    chk("clip_t3", int'(clip_cnt), 2);
    txn(7, -4, 8, 1, 20, 0);
    for (int i = 0; i < 6; i++) txn(tv[i][5], tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4]);
    mem[9] = 16'd1234;
    p_sample = 16'd999;
    p_valid = 0;
    bram_vol = 0;
    player_vol = 0;
    master_vol = 0;
    issue(9, n);
    q.push_back('{n + 2 + PT + 2, mix(1234, 0, 0, 0, 0, c)});
    @(posedge mclk); #1;
    req = 1;
    @(posedge mclk); #1;
    req = 0;
    mdrop += 2;
    repeat (PT + 1) @(posedge mclk);
    #1;
    chk("drop_timeout", int'(drop_cnt), mdrop);
    chk("clip_timeout", int'(clip_cnt), mclip);
    mem[200] = 16'hFF9C;
    p_sample = 16'd50;
    p_valid = 1;
    issue(200, n);
    q.push_back('{n + 4, -50});
    repeat (3) @(posedge mclk);
    #1;
    chk("busy_out", int'(busy), 1);
    req = 1;
    @(posedge mclk); #1;
    req = 0;
    mdrop++;
    @(posedge mclk); #1;
    chk("drop_outreq", int'(drop_cnt), mdrop);
    chk("idle_after", int'(busy), 0);
    mem[3] = 16'd500;
    p_valid = 0;
    issue(3, n);
    repeat (2) @(posedge mclk);
    #1;
    chk("play_ready", int'(p_ready), 1);
    rstn = 0;
    mclip = 0;
    mdrop = 0;
    @(negedge mclk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(p_ready), 0);
    chk("abort_clip", int'(clip_cnt), 0);
    chk("abort_drop", int'(drop_cnt), 0);
    @(posedge mclk); #1;
    rstn = 1;
    txn(3, 500, -100, 0, 0, 0);
    repeat (5) @(posedge mclk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
